// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential radix-4 Booth multiplier, one digit per cycle, signed or unsigned
module booth_mult_seq #(
    parameter int WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 tc,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int N     = WIDTH / 2 + 1;
    localparam int ACC_W = 2 * WIDTH + 2;
    localparam int MUL_W = WIDTH + 3;
    localparam int CNT_W = $clog2(N + 1);

    localparam logic [ACC_W-1:0] ACC_ONE  = ACC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [ACC_W-1:0]     mcand_q, mcand_d;
    logic [MUL_W-1:0]     mult_q, mult_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic                 accept;
    logic                 a_sign;
    logic                 b_sign;
    logic [ACC_W-1:0]     pp;
    logic [ACC_W-1:0]     acc_sum;

    assign accept = start && (state_q != RUN);
    assign a_sign = tc & a[WIDTH-1];
    assign b_sign = tc & b[WIDTH-1];

    // The multiplier register carries b[-1] = 0 in bit 0, so bits [2:0] are always the current triplet.
    always_comb begin
        pp = '0;
        case (mult_q[2:0])
            3'b001, 3'b010: pp = mcand_q;
            3'b011:         pp = mcand_q << 1;
            3'b100:         pp = ~(mcand_q << 1) + ACC_ONE;
            3'b101, 3'b110: pp = ~mcand_q + ACC_ONE;
            default:        pp = '0;
        endcase
    end

    assign acc_sum = acc_q + pp;

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mult_d    = mult_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            RUN: begin
                acc_d   = acc_sum;
                mcand_d = mcand_q << 2;
                mult_d  = {{2{mult_q[MUL_W-1]}}, mult_q[MUL_W-1:2]};
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    product_d = acc_sum[2*WIDTH-1:0];
                    state_d   = DONE;
                end
            end
            default: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                if (accept) begin
                    mcand_d = {{(ACC_W-WIDTH){a_sign}}, a};
                    mult_d  = {{2{b_sign}}, b, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mult_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mult_q    <= mult_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb/tb_booth_mult_seq.sv - self-checking bench for booth_mult_seq at WIDTH 8 and 4
module tb_booth_mult_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, tc;
    logic [7:0]  a, b;
    logic        busy, done;
    logic [15:0] product;
    logic        start4, tc4;
    logic [3:0]  a4, b4;
    logic        busy4, done4;
    logic [7:0]  product4;

    int n_check = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .tc(tc), .a(a), .b(b),
        .busy(busy), .done(done), .product(product)
    );

    booth_mult_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .tc(tc4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .product(product4)
    );

    // Reference: interpret operands per tc, multiply as integers, keep the low 2*w bits.
    function automatic logic [63:0] ref_mul(input int w, input logic [31:0] ia, input logic [31:0] ib,
                                            input logic itc);
        longint sa, sb, p;
        sa = longint'(ia);
        sb = longint'(ib);
        if (itc && ia[w-1]) sa = sa - (longint'(1) << w);
        if (itc && ib[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic itc,
                        output logic [15:0] prod, output int lat);
        @(negedge clk);
        a = ia; b = ib; tc = itc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        prod = product;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; tc = 1'b0; a = '0; b = '0;
        start4 = 1'b0; tc4 = 1'b0; a4 = '0; b4 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_check++;
        if ({busy, done, product} !== 18'h0) $display("FAIL reset8 busy/done/product=%b/%b/%h required 0/0/0000", busy, done, product);
        else n_pass++;
        n_check++;
        if ({busy4, done4, product4} !== 10'h0) $display("FAIL reset4 busy/done/product=%b/%b/%h required 0/0/00", busy4, done4, product4);
        else n_pass++;
    endtask

    task automatic test_directed;
        logic [7:0]  va [5] = '{8'h80, 8'hFF, 8'hFF, 8'hFF, 8'h07};
        logic [7:0]  vb [5] = '{8'h80, 8'hFF, 8'hFF, 8'h01, 8'hFD};
        logic        vt [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] ve [5] = '{16'h4000, 16'hFE01, 16'h0001, 16'hFFFF, 16'hFFEB};
        logic [15:0] prod;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            run8(va[i], vb[i], vt[i], prod, lat);
            n_check++;
            if (lat !== 6) $display("FAIL directed%0d latency=%0d required 6", i, lat);
            else n_pass++;
            n_check++;
            if (prod !== ve[i]) $display("FAIL directed%0d product=%h required %h", i, prod, ve[i]);
            else n_pass++;
        end
    endtask

    task automatic test_ignored_start;
        logic [15:0] exp;
        logic [15:0] prev;
        exp  = 16'(ref_mul(8, 32'h5A, 32'hC3, 1'b1));
        prev = product;
        @(negedge clk);
        a = 8'h5A; b = 8'hC3; tc = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            n_check++;
            if (busy !== 1'b1 || done !== 1'b0 || product !== prev)
                $display("FAIL ign_run%0d busy/done/product=%b/%b/%h required 1/0/%h", cyc, busy, done, product, prev);
            else n_pass++;
            if (cyc == 2) begin
                start = 1'b1; a = 8'h11; b = 8'h22; tc = 1'b0;
            end
            if (cyc == 3) start = 1'b0;
            @(posedge clk); #1;
        end
        n_check++;
        if (done !== 1'b1 || busy !== 1'b0 || product !== exp)
            $display("FAIL ign_done busy/done/product=%b/%b/%h required 0/1/%h", busy, done, product, exp);
        else n_pass++;
        @(posedge clk); #1;
        n_check++;
        if (done !== 1'b0 || busy !== 1'b0 || product !== exp)
            $display("FAIL ign_idle busy/done/product=%b/%b/%h required 0/0/%h", busy, done, product, exp);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp;
        int          c;
        @(negedge clk);
        a = 8'h81; b = 8'h7F; tc = 1'b1; start = 1'b1;
        exp = 16'(ref_mul(8, 32'(a), 32'(b), tc));
        @(posedge clk); #1;
        c = 1;
        for (int j = 0; j < 6; j++) begin
            do begin
                @(posedge clk); #1;
                c++;
            end while (!done && c < 20);
            n_check++;
            if (c !== 6) $display("FAIL b2b%0d done_spacing=%0d required 6", j, c);
            else n_pass++;
            n_check++;
            if (product !== exp) $display("FAIL b2b%0d product=%h required %h", j, product, exp);
            else n_pass++;
            a = 8'(8'h35 * (j + 2)); b = 8'(8'hC7 + 8'(j * 29)); tc = j[0];
            exp = 16'(ref_mul(8, 32'(a), 32'(b), tc));
            if (j == 5) start = 1'b0;
            c = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int seen;
        @(negedge clk);
        a = 8'h12; b = 8'h34; tc = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_check++;
        if ({busy, done, product} !== 18'h0) $display("FAIL rstmid busy/done/product=%b/%b/%h required 0/0/0000", busy, done, product);
        else n_pass++;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        n_check++;
        if (seen !== 0) $display("FAIL rstmid_nodone activity_cycles=%0d required 0", seen);
        else n_pass++;
    endtask

    task automatic test_random8;
        logic [15:0] exp;
        int          c;
        @(negedge clk);
        a = 8'($urandom); b = 8'($urandom); tc = 1'($urandom); start = 1'b1;
        exp = 16'(ref_mul(8, 32'(a), 32'(b), tc));
        @(posedge clk); #1;
        c = 1;
        for (int j = 0; j < 10000; j++) begin
            do begin
                @(posedge clk); #1;
                c++;
            end while (!done && c < 20);
            n_check++;
            if (c !== 6 || product !== exp)
                $display("FAIL rand8_%0d spacing=%0d product=%h required 6 and %h", j, c, product, exp);
            else n_pass++;
            a = 8'($urandom); b = 8'($urandom); tc = 1'($urandom);
            exp = 16'(ref_mul(8, 32'(a), 32'(b), tc));
            if (j == 9999) start = 1'b0;
            c = 0;
        end
    endtask

    task automatic test_exhaustive4;
        logic [7:0] exp;
        logic [8:0] k;
        int         c;
        @(negedge clk);
        k = '0;
        tc4 = k[8]; a4 = k[7:4]; b4 = k[3:0]; start4 = 1'b1;
        exp = 8'(ref_mul(4, 32'(a4), 32'(b4), tc4));
        @(posedge clk); #1;
        c = 1;
        for (int j = 0; j < 512; j++) begin
            do begin
                @(posedge clk); #1;
                c++;
            end while (!done4 && c < 20);
            n_check++;
            if (c !== 4 || product4 !== exp)
                $display("FAIL exh4 tc=%b a=%h b=%h spacing=%0d product=%h required 4 and %h", tc4, a4, b4, c, product4, exp);
            else n_pass++;
            k = 9'(j + 1);
            tc4 = k[8]; a4 = k[7:4]; b4 = k[3:0];
            exp = 8'(ref_mul(4, 32'(a4), 32'(b4), tc4));
            if (j == 511) start4 = 1'b0;
            c = 0;
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_ignored_start;
        test_back_to_back;
        test_reset_mid;
        fork
            test_random8;
            test_exhaustive4;
        join
        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
